// File: rtl/shifter_right_seq.sv
// Purpose : multicycle 32-bit right barrel shifter (SRL/SRA, optional ROR), one power-of-two stage per clock.
// Latency : operand accepted at edge N, result valid after edge N+5 regardless of shamt (one op per 7 cycles max).
// Backpressure: in_ready only in IDLE; result and out_valid held stable in DONE until out_ready.
//
// Optional feature macro: SHIFTER_RIGHT_ROTATE_EN -- when defined, mode=10 rotates right;
// when undefined, mode=10 decodes as SRL and no rotate logic exists.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (aborts any operation in flight)
//   in_valid   operand valid          in_ready  block idle, can accept
//   data       operand                shamt     shift amount 0..31
//   mode       00 SRL, 01 SRA, 10 ROR (with macro, else SRL), 11 SRL
//   out_valid  result valid           out_ready consumer accepts result
//   dataOut    shifted result; updated only on the final stage, 0 after reset
module shifter_right_seq #(
    parameter int WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          data,
    input  logic [$clog2(WIDTH)-1:0]  shamt,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          dataOut
);

    localparam int SW = $clog2(WIDTH);   // shamt width = number of stages
    localparam int KW = $clog2(SW);      // stage counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;          // index of the stage applied on the next edge
    logic [WIDTH-1:0] work;      // working register
    logic [SW-1:0]   amt;        // latched shamt
    logic            sra;        // latched: arithmetic shift selected
    logic            sign;       // latched data[MSB], fill bit for SRA
`ifdef SHIFTER_RIGHT_ROTATE_EN
    logic            ror;        // latched: rotate selected
    logic [SW:0]     rot_amt;    // left shift that brings the dropped LSBs to the top
`endif

    logic [SW-1:0]    sh;        // 2^k, shift distance of the current stage
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] stage_val; // working register after applying stage k

    always_comb begin
        sh        = SW'(1) << k;
        shifted   = work >> sh;
        // Vacated MSBs take the sign captured at accept, not the current work MSB.
        fill      = (sra && sign) ? ~({WIDTH{1'b1}} >> sh) : '0;
        stage_val = shifted | fill;
`ifdef SHIFTER_RIGHT_ROTATE_EN
        rot_amt   = (SW+1)'(WIDTH) - {1'b0, sh};
        if (ror) begin
            stage_val = shifted | (work << rot_amt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            work      <= '0;
            amt       <= '0;
            sra       <= 1'b0;
            sign      <= 1'b0;
`ifdef SHIFTER_RIGHT_ROTATE_EN
            ror       <= 1'b0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dataOut   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= data;
                        amt      <= shamt;
                        sra      <= (mode == 2'b01);
                        sign     <= data[WIDTH-1];
`ifdef SHIFTER_RIGHT_ROTATE_EN
                        ror      <= (mode == 2'b10);
`endif
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (amt[k]) begin
                        work <= stage_val;
                    end
                    k <= k + 1'b1;
                    // Last stage: publish the result straight from the stage output.
                    if (k == KW'(SW-1)) begin
                        dataOut   <= amt[k] ? stage_val : work;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // No accept here even on the handshake cycle; IDLE reopens in_ready.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_right_seq.sv
module tb_shifter_right_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;

    shifter_right_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  m;
        logic [31:0] e;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    // Reference: plain arithmetic on the whole operand.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] m);
        logic signed [31:0] sd;
        sd = d;
        case (m)
            2'b01: return sd >>> s;
`ifdef SHIFTER_RIGHT_ROTATE_EN
            2'b10: return (s == 0) ? d : ((d >> s) | (d << (32 - int'(s))));
`endif
            default: return d >> s;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block expected idle.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] m, input logic [31:0] exp, input int hold);
        int lat;
        check({name, " in_ready before"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        data     = d;
        shamt    = s;
        mode     = m;
        @(negedge clk);
        // Operands are sampled only at accept; scramble them afterwards.
        in_valid = 1'b0;
        data     = $urandom;
        shamt    = 5'($urandom);
        mode     = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat == 2) begin
                check({name, " in_ready shift"}, {31'd0, in_ready}, 32'd0);
                in_valid = 1'b1;        // must be ignored while busy
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        check({name, " latency"}, lat, 32'd5);
        check({name, " result"}, dataOut, exp);
        check({name, " in_ready done"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " hold result"}, dataOut, exp);
            check({name, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after hs"}, {31'd0, out_valid}, 32'd0);
        check({name, " in_ready after hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 5'd31, 2'b00, 32'h0000_0001, 0};
        vecs[1] = '{32'h8000_0000, 5'd4,  2'b01, 32'hF800_0000, 0};
        vecs[2] = '{32'h7FFF_FFFF, 5'd8,  2'b01, 32'h007F_FFFF, 1};
        vecs[3] = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 3};
`ifdef SHIFTER_RIGHT_ROTATE_EN
        vecs[4] = '{32'h0000_0001, 5'd1,  2'b10, 32'h8000_0000, 0};
`else
        vecs[4] = '{32'h0000_0001, 5'd1,  2'b10, 32'h0000_0000, 0};
`endif
        vecs[5] = '{32'hF0F0_F0F0, 5'd4,  2'b11, 32'h0F0F_0F0F, 0};
        vecs[6] = '{32'h8000_0001, 5'd31, 2'b01, 32'hFFFF_FFFF, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = '0;
        shamt     = '0;
        mode      = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset dataOut", dataOut, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].e,
                   vecs[i].hold);
        end

        // Reset while at stage k=2: operation aborted, result never shown.
        in_valid = 1'b1;
        data     = 32'hFFFF_0000;
        shamt    = 5'd3;
        mode     = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst dataOut", dataOut, 32'd0);
        repeat (6) @(negedge clk);
        check("midrst discarded", {31'd0, out_valid}, 32'd0);
        run_op("after rst", 32'h0000_0100, 5'd8, 2'b00, 32'h0000_0001, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic [1:0]  m;
            d = $urandom;
            s = 5'($urandom);
            m = 2'($urandom);
            run_op($sformatf("rand%0d", i), d, s, m, ref_model(d, s, m),
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
